// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state codes and
// status-word bit positions used by mem_ctrl when the CPU polls the sender.
package uart_tx_buffered_pkg;

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t UART_IDLE  = 2'd0;
    localparam uart_state_t UART_START = 2'd1;
    localparam uart_state_t UART_DATA  = 2'd2;
    localparam uart_state_t UART_STOP  = 2'd3;

    localparam int UART_STA_BUSY = 0;
    localparam int UART_STA_FULL = 1;

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// Byte-wide synchronous FIFO; head entry is shown on dout combinationally.
// A push into a full FIFO is taken only when a pop frees a slot on the same edge.
module sync_fifo_8b #(
    parameter int FIFO_AW = 4
) (
    input  logic               clk_i_w,
    input  logic               rst_i_w,
    input  logic               push,
    input  logic [7:0]         din,
    input  logic               pop,
    output logic [7:0]         dout,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   count
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] PTR_ONE    = {{FIFO_AW{1'b0}}, 1'b1};

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic             pop_acc;
    logic             push_acc;

    // Extra pointer MSB separates full from empty; subtraction wraps naturally.
    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == FULL_COUNT);
    assign empty    = (wr_ptr == rd_ptr);
    assign pop_acc  = pop && !empty;
    assign push_acc = push && (!full || pop_acc);
    assign dout     = mem[rd_ptr[FIFO_AW-1:0]];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i_w or negedge rst_i_w) begin
        if (!rst_i_w) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_acc)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_i_w) begin
        if (push_acc) mem[wr_ptr[FIFO_AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: FIFO in front of a start/data/stop serializer,
// with a registered busy/full status word polled by the CPU.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLKS_PER_BIT = 208,
    parameter int FIFO_AW      = 4
) (
    input  logic       clk_i_w,
    input  logic       rst_i_w,
    input  logic       en_i_w,
    input  logic       send_i_w,
    input  logic [7:0] schar_i_w,
    output logic [1:0] sta_o_r,
    output logic       txd_o_r
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]    BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]    BAUD_ONE   = BW'(1);
    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(2 ** FIFO_AW);
    localparam logic [FIFO_AW:0] CNT_ONE    = {{FIFO_AW{1'b0}}, 1'b1};

    uart_state_t      state, state_nxt;
    logic [BW-1:0]    baud_cnt, baud_nxt;
    logic [2:0]       bit_cnt, bit_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             txd_nxt;
    logic [1:0]       sta_nxt;

    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_AW:0] fifo_count;
    logic [FIFO_AW:0] count_nxt;
    logic             pop;
    logic             push_acc;
    logic             baud_end;

    assign pop      = (state == UART_IDLE) && en_i_w && !fifo_empty;
    assign push_acc = send_i_w && (!fifo_full || pop);
    assign baud_end = (baud_cnt == BAUD_LAST);

    sync_fifo_8b #(.FIFO_AW(FIFO_AW)) u_fifo (
        .clk_i_w (clk_i_w),
        .rst_i_w (rst_i_w),
        .push    (send_i_w),
        .din     (schar_i_w),
        .pop     (pop),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        txd_nxt   = txd_o_r;
        if (en_i_w) begin
            if (state == UART_IDLE) begin
                txd_nxt = 1'b1;
                if (pop) begin
                    state_nxt = UART_START;
                    baud_nxt  = '0;
                    shift_nxt = fifo_dout;
                    txd_nxt   = 1'b0;
                end
            end else if (!baud_end) begin
                baud_nxt = baud_cnt + BAUD_ONE;
            end else begin
                baud_nxt = '0;
                case (state)
                    UART_START: begin
                        state_nxt = UART_DATA;
                        bit_nxt   = '0;
                        txd_nxt   = shift[0];
                    end
                    UART_DATA: begin
                        if (bit_cnt == 3'd7) begin
                            state_nxt = UART_STOP;
                            txd_nxt   = 1'b1;
                        end else begin
                            shift_nxt = {1'b0, shift[7:1]};
                            bit_nxt   = bit_cnt + 3'd1;
                            txd_nxt   = shift[1];
                        end
                    end
                    default: begin
                        state_nxt = UART_IDLE;
                        txd_nxt   = 1'b1;
                    end
                endcase
            end
        end
    end

    // Status is registered from next-state values so it lines up with txd_o_r.
    always_comb begin
        count_nxt = fifo_count;
        if (push_acc && !pop)      count_nxt = fifo_count + CNT_ONE;
        else if (!push_acc && pop) count_nxt = fifo_count - CNT_ONE;
        sta_nxt                = 2'b00;
        sta_nxt[UART_STA_FULL] = (count_nxt == FULL_COUNT);
        sta_nxt[UART_STA_BUSY] = (count_nxt != '0) || (state_nxt != UART_IDLE);
    end

    always_ff @(posedge clk_i_w or negedge rst_i_w) begin
        if (!rst_i_w) begin
            state    <= UART_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            txd_o_r  <= 1'b1;
            sta_o_r  <= 2'b00;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            shift    <= shift_nxt;
            txd_o_r  <= txd_nxt;
            sta_o_r  <= sta_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with CLKS_PER_BIT=4, FIFO_AW=2; a line
// monitor decodes frames into a queue with their start-bit cycle stamps.
module tb_uart_tx_buffered;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       send;
    logic [7:0] schar;
    logic [1:0] sta;
    logic       txd;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] rx_q[$];
    int         rx_t[$];
    int         rx_ferr = 0;
    logic       mon_on  = 1'b0;
    int         mon_ph  = 0;
    int         mon_k   = 0;
    int         mon_t   = 0;
    logic [7:0] mon_b   = 8'h00;

    uart_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_AW(2)) dut (
        .clk_i_w   (clk),
        .rst_i_w   (rst_n),
        .en_i_w    (en),
        .send_i_w  (send),
        .schar_i_w (schar),
        .sta_o_r   (sta),
        .txd_o_r   (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Line receiver: start detected at s=0, bit i sampled mid-bit at s=4*i+6, stop at s=38.
    always @(negedge clk) begin
        if (!mon_on) begin
            mon_ph = 0;
        end else if (mon_ph == 0) begin
            if (txd === 1'b0) begin
                mon_ph = 1;
                mon_k  = 0;
                mon_t  = cyc;
                mon_b  = 8'h00;
            end
        end else begin
            mon_k++;
            if (mon_k >= 6 && mon_k <= 34 && ((mon_k - 6) % 4) == 0)
                mon_b[3'((mon_k - 6) / 4)] = txd;
            if (mon_k == 38) begin
                if (txd !== 1'b1) rx_ferr++;
                rx_q.push_back(mon_b);
                rx_t.push_back(mon_t);
            end
            if (mon_k == 39) mon_ph = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        send  = 1'b1;
        schar = b;
        tick();
        send  = 1'b0;
    endtask

    function automatic logic exp_txd(input logic [7:0] b, input int s);
        if (s < 4)       return 1'b0;
        else if (s < 36) return b[3'((s - 4) / 4)];
        else             return 1'b1;
    endfunction

    task automatic clear_rx();
        rx_q.delete();
        rx_t.delete();
        rx_ferr = 0;
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int left;
        left = budget;
        while (rx_q.size() < n && left > 0) begin
            tick();
            left--;
        end
        total++;
        if (rx_q.size() < n) begin
            bad++;
            $display("FAIL %s timeout: frames=%0d need=%0d", tag, rx_q.size(), n);
        end
    endtask

    task automatic check_rx(input int i, input logic [7:0] exp, input string tag);
        logic [7:0] got;
        got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s byte%0d: got=%02h exp=%02h", tag, i, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        send  = 1'b0;
        schar = 8'h00;
        #12;
        total++;
        if (txd !== 1'b1 || sta !== 2'b00) begin
            bad++;
            $display("FAIL reset_hold: txd=%b sta=%b exp txd=1 sta=00", txd, sta);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) tick();
        total++;
        if (txd !== 1'b1 || sta !== 2'b00) begin
            bad++;
            $display("FAIL reset_release: txd=%b sta=%b exp txd=1 sta=00", txd, sta);
        end
        mon_on = 1'b1;
    endtask

    task automatic test_single_frame();
        logic [7:0] b;
        logic       e;
        b = 8'hA5;
        clear_rx();
        push_byte(b);
        total++;
        if (txd !== 1'b1 || sta !== 2'b01) begin
            bad++;
            $display("FAIL single_push: txd=%b sta=%b exp txd=1 sta=01", txd, sta);
        end
        for (int s = 0; s < 40; s++) begin
            tick();
            e = exp_txd(b, s);
            total++;
            if (txd !== e || sta !== 2'b01) begin
                bad++;
                $display("FAIL single_wave s=%0d: txd=%b sta=%b exp txd=%b sta=01", s, txd, sta, e);
            end
        end
        tick();
        total++;
        if (txd !== 1'b1 || sta !== 2'b00) begin
            bad++;
            $display("FAIL single_end: txd=%b sta=%b exp txd=1 sta=00", txd, sta);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [5];
        bytes = '{8'h31, 8'hC2, 8'h0F, 8'h80, 8'h55};
        clear_rx();
        send = 1'b1;
        for (int i = 0; i < 5; i++) begin
            schar = bytes[i];
            tick();
            if (i == 1) begin
                total++;
                if (txd !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_first_pop: txd=%b exp 0", txd);
                end
            end
        end
        send = 1'b0;
        total++;
        if (sta !== 2'b11) begin
            bad++;
            $display("FAIL b2b_full: sta=%b exp 11", sta);
        end
        wait_rx(5, 400, "b2b");
        for (int i = 0; i < 5; i++) check_rx(i, bytes[i], "b2b");
        for (int i = 0; i + 1 < rx_t.size(); i++) begin
            total++;
            if (rx_t[i+1] - rx_t[i] !== 41) begin
                bad++;
                $display("FAIL b2b_pitch%0d: got=%0d exp=41", i, rx_t[i+1] - rx_t[i]);
            end
        end
        total++;
        if (rx_ferr !== 0) begin
            bad++;
            $display("FAIL b2b_stop: framing errors=%0d exp 0", rx_ferr);
        end
        repeat (3) tick();
        total++;
        if (sta !== 2'b00) begin
            bad++;
            $display("FAIL b2b_idle: sta=%b exp 00", sta);
        end
    endtask

    task automatic test_full_drop();
        logic [7:0] bytes [4];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        clear_rx();
        en = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(bytes[i]);
        total++;
        if (sta !== 2'b11) begin
            bad++;
            $display("FAIL drop_fill: sta=%b exp 11", sta);
        end
        push_byte(8'hFF);
        total++;
        if (sta !== 2'b11 || txd !== 1'b1) begin
            bad++;
            $display("FAIL drop_push: sta=%b txd=%b exp sta=11 txd=1", sta, txd);
        end
        en = 1'b1;
        wait_rx(4, 300, "drop");
        repeat (60) tick();
        total++;
        if (rx_q.size() !== 4) begin
            bad++;
            $display("FAIL drop_count: frames=%0d exp 4", rx_q.size());
        end
        for (int i = 0; i < 4; i++) check_rx(i, bytes[i], "drop");
        total++;
        if (sta !== 2'b00) begin
            bad++;
            $display("FAIL drop_idle: sta=%b exp 00", sta);
        end
    endtask

    task automatic test_enable_pause();
        logic [7:0] b;
        logic       e;
        int         left;
        b = 8'hF7;
        mon_on = 1'b0;
        push_byte(b);
        left = 10;
        while (txd !== 1'b0 && left > 0) begin
            tick();
            left--;
        end
        total++;
        if (txd !== 1'b0) begin
            bad++;
            $display("FAIL pause_start timeout: txd=%b exp 0", txd);
        end
        for (int s = 1; s <= 17; s++) begin
            tick();
            e = exp_txd(b, s);
            total++;
            if (txd !== e) begin
                bad++;
                $display("FAIL pause_pre s=%0d: txd=%b exp=%b", s, txd, e);
            end
        end
        en = 1'b0;
        for (int f = 0; f < 10; f++) begin
            tick();
            total++;
            if (txd !== 1'b0 || sta !== 2'b01) begin
                bad++;
                $display("FAIL pause_frozen f=%0d: txd=%b sta=%b exp txd=0 sta=01", f, txd, sta);
            end
        end
        en = 1'b1;
        for (int s = 18; s < 40; s++) begin
            tick();
            e = exp_txd(b, s);
            total++;
            if (txd !== e) begin
                bad++;
                $display("FAIL pause_post s=%0d: txd=%b exp=%b", s, txd, e);
            end
        end
        tick();
        total++;
        if (txd !== 1'b1 || sta !== 2'b00) begin
            bad++;
            $display("FAIL pause_end: txd=%b sta=%b exp txd=1 sta=00", txd, sta);
        end
        clear_rx();
        mon_on = 1'b1;
    endtask

    task automatic test_async_reset();
        logic stray;
        clear_rx();
        send = 1'b1;
        schar = 8'h00;
        repeat (3) tick();
        send = 1'b0;
        repeat (10) tick();
        total++;
        if (txd !== 1'b0 || sta !== 2'b01) begin
            bad++;
            $display("FAIL areset_pre: txd=%b sta=%b exp txd=0 sta=01", txd, sta);
        end
        mon_on = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (txd !== 1'b1 || sta !== 2'b00) begin
            bad++;
            $display("FAIL areset_async: txd=%b sta=%b exp txd=1 sta=00", txd, sta);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_rx();
        mon_on = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (txd !== 1'b1 || sta !== 2'b00) stray = 1'b1;
        end
        total++;
        if (stray !== 1'b0 || rx_q.size() !== 0) begin
            bad++;
            $display("FAIL areset_quiet: activity=%b frames=%0d exp 0 0", stray, rx_q.size());
        end
        push_byte(8'h3C);
        wait_rx(1, 100, "areset_new");
        check_rx(0, 8'h3C, "areset_new");
        repeat (45) tick();
    endtask

    task automatic test_push_pop_full();
        logic [7:0] bytes [5];
        bytes = '{8'h01, 8'h80, 8'h7E, 8'hC3, 8'h99};
        clear_rx();
        en = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(bytes[i]);
        total++;
        if (sta !== 2'b11) begin
            bad++;
            $display("FAIL pp_fill: sta=%b exp 11", sta);
        end
        en = 1'b1;
        push_byte(bytes[4]);
        total++;
        if (sta !== 2'b11 || txd !== 1'b0) begin
            bad++;
            $display("FAIL pp_same_cycle: sta=%b txd=%b exp sta=11 txd=0", sta, txd);
        end
        wait_rx(5, 400, "pp");
        for (int i = 0; i < 5; i++) check_rx(i, bytes[i], "pp");
        repeat (5) tick();
        total++;
        if (sta !== 2'b00) begin
            bad++;
            $display("FAIL pp_idle: sta=%b exp 00", sta);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_full_drop();
        test_enable_pause();
        test_async_reset();
        test_push_pop_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
